// File: rtl/sel_f2a_if.sv
// Host-to-FPGA selector bus: FTDI receive side, TX IQ FIFO, ECPU inbound FIFO and status.
`timescale 1ns/1ps
interface sel_f2a_if #(
  parameter int FT_DATA_WIDTH = 32,
  parameter int IQ_PAIR_WIDTH = 24
);
  logic [FT_DATA_WIDTH-1:0] data_i;
  logic                     empty_i;
  logic                     re_o;
  logic [IQ_PAIR_WIDTH-1:0] fifo_data_o;
  logic                     fifo_we_o;
  logic                     fifo_afull_i;
  logic [FT_DATA_WIDTH-1:0] cpu_data_o;
  logic                     cpu_we_o;
  logic                     cpu_afull_i;
  logic [3:0]               cpu_blkcnt_o;
  logic [7:0]               err_cnt_o;
  logic                     busy_o;

  // The selector drives the read strobe, sink writes and status.
  modport master (
    input  data_i, empty_i, fifo_afull_i, cpu_afull_i,
    output re_o, fifo_data_o, fifo_we_o, cpu_data_o, cpu_we_o,
           cpu_blkcnt_o, err_cnt_o, busy_o
  );

  modport slave (
    output data_i, empty_i, fifo_afull_i, cpu_afull_i,
    input  re_o, fifo_data_o, fifo_we_o, cpu_data_o, cpu_we_o,
           cpu_blkcnt_o, err_cnt_o, busy_o
  );
endinterface

// File: rtl/sel_f2a.sv
// Parses one-word packet headers from the FTDI receive path and routes payload words
// to the TX IQ FIFO (unpacked to {Q,I}) or the ECPU inbound FIFO; unknown types are drained.
`timescale 1ns/1ps
module sel_f2a #(
  parameter int FT_DATA_WIDTH    = 32,
  parameter int IQ_PAIR_WIDTH    = 24,
  parameter int QSTART_BIT_INDEX = 16
) (
  input logic       clk_i,
  input logic       reset,
  sel_f2a_if.master bus
);
  localparam int HALF_W = IQ_PAIR_WIDTH / 2;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_FIFO  = 4'b0010,
    ST_CPU   = 4'b0100,
    ST_DRAIN = 4'b1000
  } state_t;

  state_t                   state;
  logic [15:0]              remain;
  logic [3:0]               blkcnt;
  logic [7:0]               err_cnt;

  logic                     rd_p0;
  logic                     last_p0;
  logic [1:0]               hdr_type_p0;
  logic [15:0]              hdr_len_p0;
  logic [IQ_PAIR_WIDTH-1:0] iq_pair_p0;

  logic                     fifo_we_p1;
  logic [IQ_PAIR_WIDTH-1:0] fifo_data_p1;
  logic                     cpu_we_p1;
  logic [FT_DATA_WIDTH-1:0] cpu_data_p1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0: consume decision, header fields and IQ unpacking from the current word
  always_comb begin
    rd_p0 = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE, ST_DRAIN: rd_p0 = ~bus.empty_i;
        ST_FIFO:           rd_p0 = ~bus.empty_i & ~bus.fifo_afull_i;
        ST_CPU:            rd_p0 = ~bus.empty_i & ~bus.cpu_afull_i;
        default:           rd_p0 = 1'b0;
      endcase
    end
  end

  assign last_p0     = (remain == 16'd0);
  assign hdr_type_p0 = bus.data_i[FT_DATA_WIDTH-1 -: 2];
  assign hdr_len_p0  = bus.data_i[15:0];
  assign iq_pair_p0  = {bus.data_i[QSTART_BIT_INDEX +: HALF_W], bus.data_i[0 +: HALF_W]};

  // Stage p1: registered sink writes, one cycle after the consuming read strobe
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state        <= ST_IDLE;
      remain       <= 16'd0;
      blkcnt       <= 4'd0;
      err_cnt      <= 8'd0;
      fifo_we_p1   <= 1'b0;
      fifo_data_p1 <= '0;
      cpu_we_p1    <= 1'b0;
      cpu_data_p1  <= '0;
    end else begin
      fifo_we_p1 <= 1'b0;
      cpu_we_p1  <= 1'b0;
      if (rd_p0) begin
        case (state)
          ST_IDLE: begin
            remain <= hdr_len_p0;
            case (hdr_type_p0)
              2'b00:   state <= ST_FIFO;
              2'b01:   state <= ST_CPU;
              default: begin
                state   <= ST_DRAIN;
                err_cnt <= sat_inc8(err_cnt);
              end
            endcase
          end
          ST_FIFO: begin
            fifo_we_p1   <= 1'b1;
            fifo_data_p1 <= iq_pair_p0;
          end
          ST_CPU: begin
            cpu_we_p1   <= 1'b1;
            cpu_data_p1 <= bus.data_i;
          end
          default: ;
        endcase
        // Payload word accounting; the last word returns to idle on the same edge
        if (state != ST_IDLE) begin
          if (last_p0) begin
            state <= ST_IDLE;
            if (state == ST_CPU) blkcnt <= blkcnt + 4'd1;
          end else begin
            remain <= remain - 16'd1;
          end
        end
      end
    end
  end

  assign bus.re_o         = rd_p0;
  assign bus.fifo_we_o    = fifo_we_p1;
  assign bus.fifo_data_o  = fifo_data_p1;
  assign bus.cpu_we_o     = cpu_we_p1;
  assign bus.cpu_data_o   = cpu_data_p1;
  assign bus.cpu_blkcnt_o = blkcnt;
  assign bus.err_cnt_o    = err_cnt;
  assign bus.busy_o       = (state != ST_IDLE);
endmodule

// File: tb/tb_sel_f2a.sv
// Directed/randomized bench for sel_f2a against a packet-level reference model.
`timescale 1ns/1ps
module tb_sel_f2a;
  localparam int K_NONE = 0;
  localparam int K_IQ   = 1;
  localparam int K_CPU  = 2;

  typedef struct {
    logic [31:0] w;
    int          kind;
    bit          hdr;
    bit          bad;
    bit          last;
  } word_t;

  logic clk_i = 1'b0;
  logic reset = 1'b1;
  always #5 clk_i = ~clk_i;

  sel_f2a_if #(.FT_DATA_WIDTH(32), .IQ_PAIR_WIDTH(24)) bus ();

  sel_f2a #(
    .FT_DATA_WIDTH(32),
    .IQ_PAIR_WIDTH(24),
    .QSTART_BIT_INDEX(16)
  ) dut (
    .clk_i(clk_i),
    .reset(reset),
    .bus  (bus.master)
  );

  int          checks = 0;
  int          errors = 0;
  word_t       stream[$];
  int          pay_left = 0;
  int          pay_kind = K_NONE;
  int          pend_kind = K_NONE;
  logic [31:0] pend_w = '0;
  int          m_blk = 0;
  int          m_err = 0;
  bit          m_busy = 1'b0;
  logic [31:0] last_fifo = '0;
  logic [31:0] last_cpu = '0;
  int          n_fifo = 0;
  int          n_cpu = 0;
  logic [31:0] obs_fifo[$];
  int          p_empty = 0;
  int          p_fa = 0;
  int          p_ca = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic push_hdr(input logic [31:0] h);
    word_t e;
    int    ty;
    ty       = int'(h >> 30);
    pay_left = int'(h & 32'hFFFF) + 1;
    pay_kind = (ty == 0) ? K_IQ : (ty == 1) ? K_CPU : K_NONE;
    e.w = h; e.kind = K_NONE; e.hdr = 1'b1; e.bad = (ty >= 2); e.last = 1'b0;
    stream.push_back(e);
  endtask

  task automatic push_pay(input logic [31:0] w);
    word_t e;
    pay_left--;
    e.w = w; e.kind = pay_kind; e.hdr = 1'b0; e.bad = 1'b0; e.last = (pay_left == 0);
    stream.push_back(e);
  endtask

  task automatic drive_inputs();
    if (stream.size() == 0 || int'($urandom_range(0, 999)) < p_empty) begin
      bus.empty_i = 1'b1;
      bus.data_i  = $urandom;
    end else begin
      bus.empty_i = 1'b0;
      bus.data_i  = stream[0].w;
    end
    bus.fifo_afull_i = int'($urandom_range(0, 999)) < p_fa;
    bus.cpu_afull_i  = int'($urandom_range(0, 999)) < p_ca;
  endtask

  // One clock: check outputs at negedge, update model from the consumption, new inputs after posedge
  task automatic cycle();
    bit    exp_re;
    bit    took;
    word_t e;
    @(negedge clk_i);
    chk("fifo_we", 32'(bus.fifo_we_o), 32'(pend_kind == K_IQ));
    chk("cpu_we", 32'(bus.cpu_we_o), 32'(pend_kind == K_CPU));
    if (bus.fifo_we_o) begin
      n_fifo++;
      obs_fifo.push_back(32'(bus.fifo_data_o));
    end
    if (bus.cpu_we_o) n_cpu++;
    if (pend_kind == K_IQ) last_fifo = (((pend_w >> 16) & 32'hFFF) << 12) | (pend_w & 32'hFFF);
    if (pend_kind == K_CPU) last_cpu = pend_w;
    chk("fifo_data", 32'(bus.fifo_data_o), last_fifo);
    chk("cpu_data", bus.cpu_data_o, last_cpu);
    chk("blkcnt", 32'(bus.cpu_blkcnt_o), 32'(m_blk));
    chk("err_cnt", 32'(bus.err_cnt_o), 32'(m_err));
    chk("busy", 32'(bus.busy_o), 32'(m_busy));
    if (reset || bus.empty_i) exp_re = 1'b0;
    else if (stream[0].kind == K_IQ) exp_re = !bus.fifo_afull_i;
    else if (stream[0].kind == K_CPU) exp_re = !bus.cpu_afull_i;
    else exp_re = 1'b1;
    chk("re", 32'(bus.re_o), 32'(exp_re));
    took      = bus.re_o && !bus.empty_i && !reset;
    pend_kind = K_NONE;
    if (reset) begin
      m_blk = 0; m_err = 0; m_busy = 1'b0; last_fifo = '0; last_cpu = '0;
    end else if (took) begin
      e         = stream.pop_front();
      pend_kind = e.kind;
      pend_w    = e.w;
      if (e.hdr) m_busy = 1'b1;
      if (e.bad) m_err = (m_err == 255) ? 255 : m_err + 1;
      if (e.last) begin
        m_busy = 1'b0;
        if (e.kind == K_CPU) m_blk = (m_blk + 1) % 16;
      end
    end
    @(posedge clk_i);
    #1;
    drive_inputs();
  endtask

  task automatic run(input int budget, output int cycles);
    cycles = 0;
    while (stream.size() > 0 || pend_kind != K_NONE) begin
      if (cycles >= budget) begin
        chk("run_timeout", 32'(stream.size()), 32'd0);
        stream.delete();
        pend_kind = K_NONE;
        break;
      end
      cycle();
      cycles++;
    end
  endtask

  initial begin
    int          cyc;
    int          base;
    logic [31:0] h;

    bus.empty_i      = 1'b0;
    bus.data_i       = 32'h4000_0000;
    bus.fifo_afull_i = 1'b0;
    bus.cpu_afull_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_re", 32'(bus.re_o), 32'd0);
    chk("rst_fifo_we", 32'(bus.fifo_we_o), 32'd0);
    chk("rst_cpu_we", 32'(bus.cpu_we_o), 32'd0);
    chk("rst_fifo_data", 32'(bus.fifo_data_o), 32'd0);
    chk("rst_cpu_data", bus.cpu_data_o, 32'd0);
    chk("rst_blkcnt", 32'(bus.cpu_blkcnt_o), 32'd0);
    chk("rst_err", 32'(bus.err_cnt_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset = 1'b0;
    drive_inputs();

    // IQ packet, no stalls
    push_hdr(32'h0000_0002);
    push_pay(32'h0ABC_0123);
    push_pay(32'h0FFF_0FFF);
    push_pay(32'hF001_F002);
    obs_fifo.delete();
    base = n_fifo;
    drive_inputs();
    run(50, cyc);
    chk("iq_count", 32'(n_fifo - base), 32'd3);
    chk("iq_val0", (obs_fifo.size() > 0) ? obs_fifo[0] : 32'hDEAD, 32'hABC123);
    chk("iq_val1", (obs_fifo.size() > 1) ? obs_fifo[1] : 32'hDEAD, 32'hFFFFFF);
    chk("iq_val2", (obs_fifo.size() > 2) ? obs_fifo[2] : 32'hDEAD, 32'h001002);
    chk("iq_idle", 32'(bus.busy_o), 32'd0);

    // CPU packet held off by cpu_afull
    p_ca = 1000;
    push_hdr(32'h4000_0000);
    push_pay(32'hDEAD_BEEF);
    base = n_cpu;
    drive_inputs();
    repeat (5) cycle();
    chk("cpu_stall_left", 32'(stream.size()), 32'd1);
    p_ca = 0;
    drive_inputs();
    run(50, cyc);
    chk("cpu_count", 32'(n_cpu - base), 32'd1);
    chk("cpu_word", bus.cpu_data_o, 32'hDEAD_BEEF);
    chk("cpu_blk1", 32'(bus.cpu_blkcnt_o), 32'd1);

    // Invalid packets: first one, then saturation with random gaps and type/len
    base = n_fifo + n_cpu;
    push_hdr(32'h8000_0003);
    repeat (4) push_pay($urandom);
    drive_inputs();
    run(50, cyc);
    chk("err_one", 32'(bus.err_cnt_o), 32'd1);
    chk("err_no_writes", 32'(n_fifo + n_cpu - base), 32'd0);
    p_empty = 200; p_fa = 500; p_ca = 500;
    for (int i = 0; i < 299; i++) begin
      h = {1'b1, 1'($urandom), 14'($urandom), 16'($urandom_range(0, 4))};
      push_hdr(h);
      repeat (int'(h[15:0]) + 1) push_pay($urandom);
    end
    drive_inputs();
    run(20000, cyc);
    chk("err_sat", 32'(bus.err_cnt_o), 32'd255);
    chk("err_sat_no_writes", 32'(n_fifo + n_cpu - base), 32'd0);

    // Back-to-back 1-word CPU packets, no gaps
    p_empty = 0; p_fa = 0; p_ca = 0;
    for (int i = 0; i < 17; i++) begin
      push_hdr(32'h4000_0000 | (32'($urandom_range(0, 16383)) << 16));
      push_pay($urandom);
    end
    base = n_cpu;
    drive_inputs();
    run(200, cyc);
    chk("b2b_cycles", 32'(cyc), 32'd35);
    chk("b2b_writes", 32'(n_cpu - base), 32'd17);
    chk("b2b_blkcnt", 32'(bus.cpu_blkcnt_o), 32'((1 + 17) % 16));

    // Maximum-length IQ packet with random empty/afull gaps, then a CPU header
    p_empty = 40; p_fa = 20; p_ca = 20;
    push_hdr(32'h0000_FFFF);
    for (int i = 0; i < 65536; i++) push_pay($urandom);
    push_hdr(32'h4000_0000);
    push_pay(32'h1234_5678);
    base = n_fifo;
    drive_inputs();
    run(90000, cyc);
    chk("max_count", 32'(n_fifo - base), 32'd65536);
    chk("max_next_hdr", bus.cpu_data_o, 32'h1234_5678);
    chk("max_idle", 32'(bus.busy_o), 32'd0);

    // Reset after two of ten IQ payload words
    p_empty = 0; p_fa = 0; p_ca = 0;
    push_hdr(32'h0000_0009);
    for (int i = 0; i < 10; i++) push_pay($urandom);
    drive_inputs();
    repeat (3) cycle();
    reset = 1'b1;
    stream.delete();
    push_hdr(32'h4000_0000);
    push_pay(32'hCAFE_F00D);
    drive_inputs();
    cycle();
    reset = 1'b0;
    chk("rst_mid_we", 32'(bus.fifo_we_o), 32'd0);
    chk("rst_mid_err", 32'(bus.err_cnt_o), 32'd0);
    chk("rst_mid_blk", 32'(bus.cpu_blkcnt_o), 32'd0);
    chk("rst_mid_data", 32'(bus.fifo_data_o), 32'd0);
    drive_inputs();
    run(50, cyc);
    chk("rst_next_cpu", bus.cpu_data_o, 32'hCAFE_F00D);
    chk("rst_next_blk", 32'(bus.cpu_blkcnt_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
